// File: rtl/display_timing_gen.sv
// display_timing_gen: pix_en-paced raster counters with registered x/y/valid/sync/frame_start decode
module display_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_B   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_E   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_B   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_E   = 11'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 2047 || V_TOTAL > 2047 || V_ACTIVE > 1024) begin : g_bad_geometry
    $error("display_timing_gen: geometry does not fit the 11-bit counters / 10-bit y");
  end
  logic [10:0] h_cnt, v_cnt;
  logic        h_end, v_end, act, hs_on, vs_on, origin;
  always_comb begin
    h_end  = h_cnt == H_LAST;
    v_end  = v_cnt == V_LAST;
    act    = h_cnt < HA && v_cnt < VA;
    hs_on  = h_cnt >= HS_B && h_cnt < HS_E;
    vs_on  = v_cnt >= VS_B && v_cnt < VS_E;
    origin = h_cnt == 11'd0 && v_cnt == 11'd0;
  end
  // outputs register the decode of the pre-increment counters, so pixel (h,v) appears one pix_en later
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt       <= h_end ? '0 : h_cnt + 11'd1;
      v_cnt       <= h_end ? (v_end ? '0 : v_cnt + 11'd1) : v_cnt;
      x           <= act ? h_cnt : '0;
      y           <= act ? v_cnt[9:0] : '0;
      valid       <= act;
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      frame_start <= origin;
    end
  end
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: full-size and reduced-geometry instances checked against an arithmetic pixel-index model
module tb_display_timing_gen;
  logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
  always #5 clk = ~clk;
  logic [10:0] fx, sx, ix;
  logic [9:0]  fy, sy, iy;
  logic        fv, fh, fvs, ffs, sv, sh, svs, sfs, iv, ih, ivs, ifs;
  int total = 0, bad = 0, n = 0;
  int vcnt = 0, hcnt = 0, hfirst = -1;

  display_timing_gen dut_full (.clk(clk), .reset(reset), .pix_en(pix_en), .x(fx), .y(fy),
    .valid(fv), .hsync(fh), .vsync(fvs), .frame_start(ffs));
  display_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1)) dut_small (.clk(clk), .reset(reset), .pix_en(pix_en), .x(sx), .y(sy),
    .valid(sv), .hsync(sh), .vsync(svs), .frame_start(sfs));
  display_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1)) dut_inv (.clk(clk), .reset(reset),
    .pix_en(pix_en), .x(ix), .y(iy), .valid(iv), .hsync(ih), .vsync(ivs), .frame_start(ifs));

  // n = pix_en pulses since reset; pulse k presents raster position k-1 of the frame sequence
  function automatic logic [24:0] model(int cnt, int ha, int hf, int hs, int hb, int va, int vf,
                                        int vs, int vb, bit hp, bit vp);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int p = cnt - 1;
    int h = p % ht;
    int v = (p / ht) % vt;
    bit act = h < ha && v < va;
    if (cnt == 0) return {11'd0, 10'd0, 1'b0, ~hp, ~vp, 1'b0};
    return {act ? 11'(h) : 11'd0, act ? 10'(v) : 10'd0, act,
            (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp,
            (v >= va + vf && v < va + vf + vs) ? vp : ~vp, h == 0 && v == 0};
  endfunction

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit pe);
    reset = r;
    pix_en = pe;
    @(posedge clk);
    if (r) n = 0;
    else if (pe) n++;
    #1;
    chk("full", {fx, fy, fv, fh, fvs, ffs}, model(n, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b0));
    chk("small", {sx, sy, sv, sh, svs, sfs}, model(n, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b0));
    chk("inv", {ix, iy, iv, ih, ivs, ifs}, model(n, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b1));
  endtask

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_state", {fx, fy, fv, fh, fvs, ffs}, {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 1688; i++) begin
      step(1'b0, 1'b1);
      if (i == 0) chk("first_pixel", {12'd0, fx, fv, ffs}, {12'd0, 11'd0, 1'b1, 1'b1});
      if (i == 1) chk("second_pixel", {12'd0, fx, fv, ffs}, {12'd0, 11'd1, 1'b1, 1'b0});
      if (fv) vcnt++;
      if (fh) begin
        if (hcnt == 0) hfirst = i;
        hcnt++;
      end
    end
    chk("valid_run", 25'(vcnt), 25'd1280);
    chk("hsync_width", 25'(hcnt), 25'd112);
    chk("hsync_start", 25'(hfirst), 25'd1328);
    step(1'b0, 1'b1);
    chk("line_wrap", {4'd0, fx, fy}, {4'd0, 11'd0, 10'd1});
    for (int i = 0; i < 3 * 1688; i++) step(1'b0, i % 3 == 0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("midline_reset", {fx, fy, fv, fh, fvs, ffs}, {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("restart_origin", {12'd0, fx, fv, ffs}, {12'd0, 11'd0, 1'b1, 1'b1});
    for (int i = 0; i < 20000; i++) step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
